// File: rtl/tdc_event_packer.sv
// Timestamps TDC hits against a free-running coarse counter and packs them into 64-bit words.
// Emits rollover markers, buffers words in a small FIFO and presents them with a done strobe.
module tdc_event_packer #(
    parameter int unsigned COARSE_W  = 40,
    parameter int unsigned FINE_W    = 8,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         clear_stats,
    input  logic                         hit_valid,
    input  logic [3:0]                   hit_ch,
    input  logic [FINE_W-1:0]            hit_fine,
    input  logic                         hold,
    output logic [63:0]                  dout,
    output logic                         done,
    output logic [$clog2(BUF_DEPTH):0]   buf_level,
    output logic [15:0]                  drop_cnt
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP
    } state_t;

    state_t              state;
    logic [COARSE_W-1:0] coarse;
    logic [29:0]         roll_cnt;
    logic                marker_pend;
    logic [63:0]         mem [BUF_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic        pop_c;
    logic        hit_acc_c;
    logic        room_c;
    logic        push_hit_c;
    logic        push_mk_c;
    logic        push_c;
    logic        drop_c;
    logic        wrap_c;
    logic [63:0] wdata_c;

    // Push/pop arbitration; a same-cycle pop frees a slot for the incoming word.
    always_comb begin
        pop_c      = (state == S_IDLE) && (buf_level != '0) && !hold;
        hit_acc_c  = hit_valid && enable;
        room_c     = (buf_level != LW'(BUF_DEPTH)) || pop_c;
        push_hit_c = hit_acc_c && room_c;
        drop_c     = hit_acc_c && !room_c;
        push_mk_c  = marker_pend && !hit_acc_c && room_c;
        push_c     = push_hit_c || push_mk_c;
        wrap_c     = &coarse;
        wdata_c    = {2'b10, roll_cnt, 16'd0, drop_cnt};
        if (hit_acc_c) begin
            wdata_c = {2'b01, hit_ch, 10'd0, coarse, hit_fine};
        end
    end

    // Word storage carries no reset; occupancy is tracked by buf_level.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wdata_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_level <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            buf_level <= buf_level + LW'(push_c) - LW'(pop_c);
        end
    end

    // Timebase and statistics; clear_stats overrides a same-cycle drop or wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coarse      <= '0;
            roll_cnt    <= '0;
            marker_pend <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            coarse <= coarse + COARSE_W'(1);
            if (push_mk_c) begin
                marker_pend <= 1'b0;
            end
            if (wrap_c) begin
                marker_pend <= 1'b1;
            end
            if (clear_stats) begin
                roll_cnt <= '0;
                drop_cnt <= '0;
            end else begin
                if (wrap_c) begin
                    roll_cnt <= roll_cnt + 30'd1;
                end
                if (drop_c && (drop_cnt != 16'hFFFF)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // Output sequencer: one word per three cycles, hold only gates a new pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            dout  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop_c) begin
                        dout  <= mem[rd_ptr];
                        done  <= 1'b1;
                        state <= S_EMIT;
                    end
                end
                S_EMIT:  state <= S_GAP;
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_event_packer.sv
// Bench for tdc_event_packer: directed vectors on a default build, plus a queue-based
// reference model checking a narrow-coarse build every cycle under random stimulus.
module tb_tdc_event_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear_stats;
    logic        hit_valid;
    logic [3:0]  hit_ch;
    logic [39:0] hit_fine40;
    logic        hold;

    logic [63:0] dout_a;
    logic        done_a;
    logic [2:0]  lvl_a;
    logic [15:0] drop_a;
    logic [63:0] dout_b;
    logic        done_b;
    logic [2:0]  lvl_b;
    logic [15:0] drop_b;

    int total = 0;
    int bad   = 0;
    int cyc;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    tdc_event_packer u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear_stats(clear_stats),
        .hit_valid  (hit_valid),
        .hit_ch     (hit_ch),
        .hit_fine   (hit_fine40[7:0]),
        .hold       (hold),
        .dout       (dout_a),
        .done       (done_a),
        .buf_level  (lvl_a),
        .drop_cnt   (drop_a)
    );

    tdc_event_packer #(.COARSE_W(8), .FINE_W(40), .BUF_DEPTH(4)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear_stats(clear_stats),
        .hit_valid  (hit_valid),
        .hit_ch     (hit_ch),
        .hit_fine   (hit_fine40),
        .hold       (hold),
        .dout       (dout_b),
        .done       (done_b),
        .buf_level  (lvl_b),
        .drop_cnt   (drop_b)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model of the narrow build: a word queue and an emitter cooldown.
    logic [63:0] mq[$];
    int          m_cool;
    bit          m_pend;
    logic [29:0] m_roll;
    logic [15:0] m_drop;
    logic [63:0] m_dout;
    bit          m_done;
    logic [7:0]  m_coarse;
    bit          m_pop;
    bit          m_acc;
    bit          m_room;
    logic [63:0] m_mk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_cool = 0; m_pend = 0; m_roll = '0; m_drop = '0;
            m_dout = '0; m_done = 0; m_coarse = '0;
        end else begin
            m_pop  = (m_cool == 0) && (mq.size() > 0) && !hold;
            m_done = 0;
            if (m_cool > 0) m_cool--;
            if (m_pop) begin
                m_dout = mq.pop_front();
                m_done = 1;
                m_cool = 2;
            end
            m_acc  = hit_valid && enable;
            m_room = mq.size() < 4;
            m_mk   = {2'b10, m_roll, 16'd0, m_drop};
            if (m_acc) begin
                if (m_room) mq.push_back({2'b01, hit_ch, 10'd0, m_coarse, hit_fine40});
                else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end else if (m_pend && m_room) begin
                mq.push_back(m_mk);
                m_pend = 0;
            end
            if (m_coarse == 8'hFF) begin
                m_pend = 1;
                m_roll = m_roll + 30'd1;
            end
            if (clear_stats) begin
                m_drop = '0;
                m_roll = '0;
            end
            m_coarse = m_coarse + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_on) begin
            chk("B_dout", dout_b, m_dout);
            chk("B_ctrl", 64'({done_b, lvl_b, drop_b}), 64'({m_done, 3'(mq.size()), m_drop}));
        end
    end

    function automatic logic [63:0] mk_a(input logic [3:0] ch, input int c, input logic [7:0] f);
        return {2'b01, ch, 10'd0, 40'(c), f};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        enable = 1'b1; clear_stats = 1'b0; hit_valid = 1'b0;
        hit_ch = '0; hit_fine40 = '0; hold = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 2000 && cyc < n; i++) @(negedge clk);
    endtask

    task automatic hit(input logic [3:0] ch, input logic [39:0] f);
        hit_valid = 1'b1; hit_ch = ch; hit_fine40 = f;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    task automatic wait_done(input bit b, input string nm);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = b ? done_b : done_a;
        end
        chk({nm, "_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic idle_cycles(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done_a) seen++;
        end
    endtask

    typedef struct {
        logic [3:0]  ch;
        logic [7:0]  fine;
        int          at;
        logic [63:0] exp;
    } vec_t;

    vec_t        vt[4];
    int          hc[6];
    int          t_prev;
    int          seen;
    logic [63:0] rnd;

    initial begin
        vt[0] = '{4'd3,  8'h5A, 100,  64'h4C00_0000_0000_645A};
        vt[1] = '{4'd15, 8'hFF, 200,  64'h7C00_0000_0000_C8FF};
        vt[2] = '{4'd0,  8'h00, 300,  64'h4000_0000_0001_2C00};
        vt[3] = '{4'd9,  8'h81, 1000, 64'h6400_0000_0003_E881};

        reset_n = 1'b0;
        do_reset();
        chk_on = 1'b1;
        chk("rst_state", 64'({dout_a, done_a, lvl_a, drop_a}), 64'd0);
        chk("rst_dout",  dout_a, 64'd0);

        // Single hits at known coarse values.
        foreach (vt[i]) begin
            wait_cyc(vt[i].at);
            chk("vec_at", 64'(cyc), 64'(vt[i].at));
            hit(vt[i].ch, {32'd0, vt[i].fine});
            wait_done(1'b0, "vec");
            chk("vec_dout", dout_a, vt[i].exp);
            chk("vec_lvl", 64'(lvl_a), 64'd0);
        end

        // Hold with six back-to-back hits: four stored, two dropped, then drain in order.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hc[i] = cyc;
            hit(4'(i + 1), 40'(8'h10 + i));
        end
        chk("hold_lvl", 64'(lvl_a), 64'd4);
        chk("hold_drop", 64'(drop_a), 64'd2);
        idle_cycles(4, seen);
        chk("hold_nodone", 64'(seen), 64'd0);
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, "drain");
            chk("drain_dout", dout_a, mk_a(4'(k + 1), hc[k], 8'(8'h10 + k)));
            if (k > 0) chk("drain_gap", 64'(cyc - t_prev), 64'd3);
            t_prev = cyc;
        end
        idle_cycles(10, seen);
        chk("drain_extra", 64'(seen), 64'd0);

        // Wrap while the buffer is full: marker waits, then carries roll=1 and drop=2.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) hit(4'(i), 40'(i));
        wait_cyc(260);
        hold = 1'b0;
        for (int k = 0; k < 5; k++) wait_done(1'b1, "mk_full");
        chk("mk_full_dout", dout_b, 64'h8000_0001_0000_0002);

        // Hit in the wrap cycle goes ahead of the marker.
        do_reset();
        wait_cyc(255);
        hit(4'd5, 40'h12_3456_789A);
        wait_done(1'b1, "wrap_hit");
        chk("wrap_hit_dout", dout_b, 64'h5400_FF12_3456_789A);
        t_prev = cyc;
        wait_done(1'b1, "wrap_mk");
        chk("wrap_mk_dout", dout_b, 64'h8000_0001_0000_0000);
        chk("wrap_mk_gap", 64'(cyc - t_prev), 64'd3);

        // Disabled hits are ignored, clear_stats, saturation, clear racing a drop.
        do_reset();
        enable = 1'b0;
        hit_valid = 1'b1;
        repeat (5) @(negedge clk);
        hit_valid = 1'b0;
        enable = 1'b1;
        idle_cycles(6, seen);
        chk("dis_done", 64'(seen), 64'd0);
        chk("dis_drop", 64'(drop_a), 64'd0);
        chk("dis_lvl", 64'(lvl_a), 64'd0);
        hold = 1'b1;
        for (int i = 0; i < 6; i++) hit(4'd1, 40'd7);
        chk("clr_pre", 64'(drop_a), 64'd2);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        chk("clr_post", 64'(drop_a), 64'd0);
        chk_on = 1'b0;
        hit_valid = 1'b1;
        repeat (65540) @(negedge clk);
        chk("sat_drop", 64'(drop_a), 64'hFFFF);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        hit_valid = 1'b0;
        chk("clr_race", 64'(drop_a), 64'd0);

        // Reset mid-emission discards the buffer and the word in flight.
        do_reset();
        chk_on = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) hit(4'd2, 40'(8'hA0 + i));
        hold = 1'b0;
        wait_done(1'b0, "pre_rst");
        chk("pre_rst_lvl", 64'(lvl_a), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_a", 64'({done_a, lvl_a, drop_a}), 64'd0);
        chk("midrst_dout", dout_a, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(20, seen);
        chk("postrst_nodone", 64'(seen), 64'd0);
        hc[0] = cyc;
        hit(4'd6, 40'h3C);
        wait_done(1'b0, "postrst");
        chk("postrst_dout", dout_a, mk_a(4'd6, hc[0], 8'h3C));

        // Random traffic against the model on the narrow build.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            hit_valid   = ($urandom % 100) < 40;
            enable      = ($urandom % 100) < 90;
            clear_stats = ($urandom % 100) < 2;
            if (($urandom % 100) < 10) hold = ~hold;
            hit_ch      = 4'($urandom);
            rnd         = {$urandom(), $urandom()};
            hit_fine40  = 40'(rnd);
            @(negedge clk);
        end
        hit_valid = 1'b0; clear_stats = 1'b0; hold = 1'b0;
        repeat (30) @(negedge clk);
        chk("rand_drained", 64'(lvl_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
